// File: rtl/dino_game_ctrl.sv
// Dinosaur runner game sequencer: IDLE/RUN/OVER control,
// jump arc timing, lift height and score, advanced once per frame.
module dino_game_ctrl #(
  parameter int JUMP_FRAMES = 30,
  parameter int SCORE_W     = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               fresh,
  input  logic               button_jump,
  input  logic               collide,
  output logic               game_status,
  output logic               game_over,
  output logic               jumping,
  output logic [11:0]        jump_height,
  output logic [SCORE_W-1:0] score
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    OVER = 2'b10,
    BAD  = 2'b11
  } state_t;

  localparam logic [5:0]  JT_END = 6'(JUMP_FRAMES);
  localparam logic [11:0] JF12   = 12'(JUMP_FRAMES);

  state_t             state;
  state_t             state_n;
  logic               fresh_q;
  logic               tick;
  logic [5:0]         jump_time;
  logic [5:0]         jump_time_n;
  logic               jumping_n;
  logic               armed;
  logic               armed_n;
  logic [SCORE_W-1:0] score_n;
  logic [11:0]        jt12;
  logic [11:0]        arc;
  logic [11:0]        height_n;

  assign tick = fresh_q & ~fresh;

  always_comb begin
    state_n     = state;
    score_n     = score;
    jump_time_n = jump_time;
    jumping_n   = jumping;
    armed_n     = armed;
    unique case (state)
      IDLE: begin
        if (tick && button_jump) begin
          state_n     = RUN;
          score_n     = '0;
          jump_time_n = '0;
          jumping_n   = 1'b0;
        end
      end
      RUN: begin
        // a collision in the tick cycle wins over the frame advance
        if (collide) begin
          state_n = OVER;
          armed_n = 1'b0;
        end else if (tick) begin
          if (!(&score))
            score_n = score + SCORE_W'(1);
          if (jumping) begin
            if (jump_time == JT_END) begin
              jump_time_n = '0;
              jumping_n   = 1'b0;
            end else begin
              jump_time_n = jump_time + 6'd1;
            end
          end else if (button_jump) begin
            jumping_n = 1'b1;
          end
        end
      end
      OVER: begin
        // restart needs a released button first
        if (tick) begin
          if (!button_jump) begin
            armed_n = 1'b1;
          end else if (armed) begin
            state_n     = RUN;
            score_n     = '0;
            jump_time_n = '0;
            jumping_n   = 1'b0;
            armed_n     = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // parabolic lift: (t*N - t*t) / 2
  always_comb begin
    jt12     = 12'(jump_time);
    arc      = jt12 * JF12 - jt12 * jt12;
    height_n = {1'b0, arc[11:1]};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      fresh_q     <= 1'b0;
      score       <= '0;
      jump_time   <= '0;
      jumping     <= 1'b0;
      armed       <= 1'b0;
      jump_height <= '0;
      game_status <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_n;
      fresh_q     <= fresh;
      score       <= score_n;
      jump_time   <= jump_time_n;
      jumping     <= jumping_n;
      armed       <= armed_n;
      jump_height <= height_n;
      game_status <= (state == RUN);
      game_over   <= (state == OVER);
    end
  end

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Bench for dino_game_ctrl: directed frame scenarios plus
// randomized frames checked against a frame-level game model.
module tb_dino_game_ctrl;

  localparam int JF   = 30;
  localparam int SW   = 8;
  localparam int SMAX = (1 << SW) - 1;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          fresh;
  logic          button_jump;
  logic          collide;
  logic          game_status;
  logic          game_over;
  logic          jumping;
  logic [11:0]   jump_height;
  logic [SW-1:0] score;

  always #5 CLK = ~CLK;

  dino_game_ctrl #(
    .JUMP_FRAMES(JF),
    .SCORE_W    (SW)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .fresh      (fresh),
    .button_jump(button_jump),
    .collide    (collide),
    .game_status(game_status),
    .game_over  (game_over),
    .jumping    (jumping),
    .jump_height(jump_height),
    .score      (score)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // game model: mode 0 idle, 1 running, 2 over
  int m_mode, m_score, m_t, m_jmp, m_armed;

  function automatic int lift(input int t);
    return (t * JF - t * t) / 2;
  endfunction

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d",
                  tag, got, exp);
  endtask

  task automatic model_reset();
    m_mode = 0; m_score = 0; m_t = 0;
    m_jmp = 0; m_armed = 0;
  endtask

  task automatic model_restart();
    m_mode = 1; m_score = 0; m_t = 0;
    m_jmp = 0; m_armed = 0;
  endtask

  task automatic model_crash();
    if (m_mode == 1) begin
      m_mode  = 2;
      m_armed = 0;
    end
  endtask

  task automatic model_tick(input int b, input int c);
    if (m_mode == 1 && c != 0) begin
      model_crash();
    end else if (m_mode == 0) begin
      if (b != 0) model_restart();
    end else if (m_mode == 1) begin
      m_score = (m_score < SMAX) ? m_score + 1 : SMAX;
      if (m_jmp != 0) begin
        if (m_t >= JF) begin
          m_t = 0; m_jmp = 0;
        end else begin
          m_t++;
        end
      end else if (b != 0) begin
        m_jmp = 1;
      end
    end else begin
      if (b == 0) m_armed = 1;
      else if (m_armed != 0) model_restart();
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".status"}, int'(game_status),
        int'(m_mode == 1));
    chk({tag, ".over"}, int'(game_over), int'(m_mode == 2));
    chk({tag, ".jumping"}, int'(jumping), m_jmp);
    chk({tag, ".height"}, int'(jump_height), lift(m_t));
    chk({tag, ".score"}, int'(score), m_score);
  endtask

  // one video frame: high phase (optional stray collide),
  // then falling edge with optional collide on the tick
  task automatic frame(input int b, input int tc,
                       input int mc);
    @(negedge CLK);
    fresh       = 1'b1;
    button_jump = b[0];
    collide     = mc[0];
    @(negedge CLK);
    collide = 1'b0;
    if (mc != 0) model_crash();
    @(negedge CLK);
    fresh   = 1'b0;
    collide = tc[0];
    @(negedge CLK);
    collide = 1'b0;
    model_tick(b, tc);
    @(negedge CLK);
    @(negedge CLK);
    check_all("frame");
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET       = 1'b1;
    fresh       = 1'b0;
    button_jump = 1'b0;
    collide     = 1'b0;
    @(negedge CLK);
    model_reset();
    check_all("reset");
    RESET = 1'b0;
  endtask

  int s_prev;

  initial begin
    RESET       = 1'b1;
    fresh       = 1'b0;
    button_jump = 1'b0;
    collide     = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    check_all("por");
    RESET = 1'b0;

    for (int i = 0; i < 3; i++) frame(0, 0, 0);

    // start: status rises two clocks after the falling edge
    @(negedge CLK);
    fresh       = 1'b1;
    button_jump = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    fresh = 1'b0;
    @(negedge CLK);
    chk("start_1clk", int'(game_status), 0);
    @(negedge CLK);
    chk("start_2clk", int'(game_status), 1);
    chk("start_score", int'(score), 0);
    model_tick(1, 0);
    button_jump = 1'b0;
    frame(0, 0, 0);
    chk("score_first", int'(score), 1);

    // jump arc with an ignored second press
    frame(1, 0, 0);
    chk("jump_start", int'(jumping), 1);
    for (int i = 1; i <= 31; i++) begin
      frame(int'(i == 8), 0, 0);
      if (i == 1)  chk("arc1", int'(jump_height), 14);
      if (i == 2)  chk("arc2", int'(jump_height), 28);
      if (i == 3)  chk("arc3", int'(jump_height), 40);
      if (i == 15) chk("peak", int'(jump_height), 112);
      if (i == 30) chk("arc_end_jmp", int'(jumping), 1);
      if (i == 30) chk("arc_end_h", int'(jump_height), 0);
      if (i == 31) chk("land", int'(jumping), 0);
    end

    // collision on a tick, then button held through it
    frame(0, 0, 0);
    s_prev = int'(score);
    frame(0, 1, 0);
    chk("crash_over", int'(game_over), 1);
    chk("crash_status", int'(game_status), 0);
    chk("crash_score", int'(score), s_prev);
    for (int i = 0; i < 5; i++) begin
      frame(1, 0, 0);
      chk("held_over", int'(game_over), 1);
    end
    frame(0, 0, 0);
    chk("armed_over", int'(game_over), 1);
    frame(1, 0, 0);
    chk("restart_run", int'(game_status), 1);
    chk("restart_score", int'(score), 0);
    chk("restart_jmp", int'(jumping), 0);

    // crash mid-arc freezes height
    frame(1, 0, 0);
    for (int i = 0; i < 4; i++) frame(0, 0, 0);
    frame(0, 1, 0);
    chk("frozen_h", int'(jump_height), 52);
    frame(0, 0, 0);
    chk("frozen_h2", int'(jump_height), 52);
    chk("frozen_jmp", int'(jumping), 1);

    // reset mid-jump
    frame(0, 0, 0);
    frame(1, 0, 0);
    frame(1, 0, 0);
    for (int i = 0; i < 10; i++) frame(0, 0, 0);
    chk("jt10_h", int'(jump_height), 100);
    do_reset();

    // score saturation
    frame(1, 0, 0);
    for (int i = 0; i < SMAX + 4; i++) frame(0, 0, 0);
    chk("score_sat", int'(score), SMAX);

    // randomized play
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      frame(int'($urandom_range(0, 2) == 0),
            int'($urandom_range(0, 19) == 0),
            int'($urandom_range(0, 24) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
